// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the GAN datapath layers:
// defaults, activation codes, layer FSM states and the saturate-and-shift helper.
package nn_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned FRAC_DEF  = 24;
    localparam int unsigned ACT_IDENT = 0;
    localparam int unsigned ACT_RELU  = 1;

    // Working width of the saturate helper; must cover any layer accumulator.
    localparam int unsigned SAT_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_FIN,
        ST_DONE
    } layer_state_t;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned n_in);
        return 2 * width + $clog2(n_in + 1);
    endfunction

    // Arithmetic right shift (floor) followed by clamping to a signed width-bit range.
    function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] val,
                                                          input int unsigned width,
                                                          input int unsigned frac);
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = val >>> frac;
        hi      = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        lo      = ~hi;
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fx_mac.sv
// Registered signed multiply-accumulate with synchronous clear; the product is
// kept at full 2*WIDTH precision before widening into the accumulator.
module fx_mac #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ACC_W = 66
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: one shared MAC walks every (neuron, input)
// pair, then bias, floor-shift, saturation and optional ReLU per neuron.
module dense_layer_seq
    import nn_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 3,
    parameter int unsigned ACT   = ACT_IDENT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN*WIDTH-1:0]         x,
    input  logic [N_OUT*N_IN*WIDTH-1:0]   w,
    input  logic [N_OUT*WIDTH-1:0]        b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_OUT*WIDTH-1:0]        y
);

    localparam int unsigned ACC_W = acc_width(WIDTH, N_IN);
    localparam int unsigned I_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int unsigned O_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
    localparam logic [O_W-1:0] O_LAST = O_W'(N_OUT - 1);

    layer_state_t state;
    layer_state_t state_next;

    logic [N_IN*WIDTH-1:0]   x_reg;
    logic [I_W-1:0]          i_cnt;
    logic [O_W-1:0]          o_cnt;
    logic                    mac_clr;
    logic                    mac_en;
    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] bias_o;
    logic signed [WIDTH-1:0] neuron;
    logic signed [ACC_W-1:0] acc;
    logic signed [SAT_W-1:0] pre;

    assign mac_a  = x_reg[int'(i_cnt) * WIDTH +: WIDTH];
    assign mac_b  = w[(int'(o_cnt) * N_IN + int'(i_cnt)) * WIDTH +: WIDTH];
    assign bias_o = b[int'(o_cnt) * WIDTH +: WIDTH];

    fx_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = rst_n;
                mac_clr  = 1'b1;
                if (in_valid) begin
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (i_cnt == I_LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                mac_clr    = 1'b1;
                state_next = (o_cnt == O_LAST) ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bias is aligned to the product scale so a single floor shift yields Q.FRAC.
    always_comb begin
        pre    = SAT_W'(acc) + (SAT_W'(bias_o) <<< FRAC);
        neuron = WIDTH'(sat_shift(pre, WIDTH, FRAC));
        if (ACT == ACT_RELU && neuron[WIDTH-1]) begin
            neuron = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg <= '0;
            i_cnt <= '0;
            o_cnt <= '0;
            y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg <= x;
                        i_cnt <= '0;
                        o_cnt <= '0;
                    end
                end
                ST_MAC: begin
                    i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
                end
                ST_FIN: begin
                    y[int'(o_cnt) * WIDTH +: WIDTH] <= neuron;
                    i_cnt <= '0;
                    if (o_cnt != O_LAST) begin
                        o_cnt <= o_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: an identity and a ReLU instance share
// stimulus; expected vectors are hand-computed fixed-point constants.
module tb_dense_layer_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned XW    = N_IN * WIDTH;
    localparam int unsigned WW    = N_OUT * N_IN * WIDTH;
    localparam int unsigned VW    = N_OUT * WIDTH;

    localparam logic [VW-1:0] ONES_X  = {3{32'h01000000}};
    localparam logic [VW-1:0] B_PASS  = {32'h01A1B252, 32'h00EF368B, 32'h00414304};
    localparam logic [VW-1:0] B_RELU  = {32'hFEE8EF7B, 32'h00EF368B, 32'h00414304};
    localparam logic [VW-1:0] Y_RELU  = {32'h00000000, 32'h00EF368B, 32'h00414304};

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [XW-1:0] x         = '0;
    logic [WW-1:0] w         = '0;
    logic [VW-1:0] b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] y;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [VW-1:0] y_r;
    logic [WW-1:0] w_tmp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dense_layer_seq #(
        .WIDTH (32),
        .FRAC  (24),
        .N_IN  (3),
        .N_OUT (3),
        .ACT   (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    dense_layer_seq #(
        .WIDTH (32),
        .FRAC  (24),
        .N_IN  (3),
        .N_OUT (3),
        .ACT   (1)
    ) dut_relu (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_r),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .y         (y_r)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input string tag, input logic [XW-1:0] xv,
                             input logic [WW-1:0] wv, input logic [VW-1:0] bv);
        check_eq({tag, " in_ready"}, 128'(in_ready), 128'(1));
        x        = xv;
        w        = wv;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x        = ~xv;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check_eq({tag, " latency"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, " out_valid drop"}, 128'(out_valid), 128'(0));
        check_eq({tag, " in_ready back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("reset out_valid", 128'(out_valid), 128'(0));
        check_eq("reset y", 128'(y), 128'(0));
        check_eq("reset in_ready", 128'(in_ready), 128'(0));
        rst_n = 1'b1;
        tick();
        check_eq("post-reset in_ready", 128'(in_ready), 128'(1));
        check_eq("post-reset out_valid", 128'(out_valid), 128'(0));

        start_txn("pass", ONES_X, '0, B_PASS);
        wait_out("pass", 12);
        check_eq("pass y", 128'(y), 128'(B_PASS));
        release_out("pass");

        w_tmp = '0;
        for (int o = 0; o < 3; o++) begin
            w_tmp[(o * 3) * 32 +: 32] = 32'h00800000;
        end
        start_txn("mac", {32'h0, 32'h0, 32'h02000000}, w_tmp, '0);
        wait_out("mac", 12);
        check_eq("mac y", 128'(y), 128'({3{32'h01000000}}));
        release_out("mac");

        w_tmp = '0;
        w_tmp[31:0] = 32'hFF800000;
        start_txn("floor", {32'h0, 32'h0, 32'h00000001}, w_tmp, '0);
        wait_out("floor", 12);
        check_eq("floor y", 128'(y), 128'({32'h0, 32'h0, 32'hFFFFFFFF}));
        release_out("floor");

        start_txn("relu", ONES_X, '0, B_RELU);
        wait_out("relu", 12);
        check_eq("relu ident y", 128'(y), 128'(B_RELU));
        check_eq("relu act y", 128'(y_r), 128'(Y_RELU));
        check_eq("relu act out_valid", 128'(out_valid_r), 128'(1));
        release_out("relu");

        start_txn("sat pos", {3{32'h64000000}}, {9{32'h64000000}}, '0);
        wait_out("sat pos", 12);
        check_eq("sat pos y", 128'(y), 128'({3{32'h7FFFFFFF}}));
        release_out("sat pos");

        start_txn("sat neg", {3{32'h64000000}}, {9{32'h9C000000}}, '0);
        wait_out("sat neg", 12);
        check_eq("sat neg y", 128'(y), 128'({3{32'h80000000}}));
        release_out("sat neg");

        start_txn("bp", ONES_X, '0, B_PASS);
        wait_out("bp", 12);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            x        = {$urandom(), $urandom(), $urandom()};
            tick();
            check_eq("bp hold out_valid", 128'(out_valid), 128'(1));
            check_eq("bp hold in_ready", 128'(in_ready), 128'(0));
            check_eq("bp hold y", 128'(y), 128'(B_PASS));
        end
        in_valid = 1'b0;
        release_out("bp");
        w_tmp = '0;
        for (int o = 0; o < 3; o++) begin
            w_tmp[(o * 3) * 32 +: 32] = 32'h00800000;
        end
        start_txn("bp next", {32'h0, 32'h0, 32'h02000000}, w_tmp, '0);
        wait_out("bp next", 12);
        check_eq("bp next y", 128'(y), 128'({3{32'h01000000}}));
        release_out("bp next");

        start_txn("rst mid", ONES_X, '0, B_PASS);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_eq("rst mid out_valid", 128'(out_valid), 128'(0));
        check_eq("rst mid y", 128'(y), 128'(0));
        check_eq("rst mid in_ready", 128'(in_ready), 128'(0));
        rst_n = 1'b1;
        tick();
        check_eq("rst release in_ready", 128'(in_ready), 128'(1));
        start_txn("rst fresh", ONES_X, '0, B_PASS);
        wait_out("rst fresh", 12);
        check_eq("rst fresh y", 128'(y), 128'(B_PASS));
        release_out("rst fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
